seqgen_tx: RTL and testbench
============================

Name: seqgen_tx

Overview:
- Serial pattern generator; the transmit side for the team's serial sequence detectors.
- Accepts a parallel pattern, repeat count and inter-repetition gap on a start strobe.
- Emits the pattern MSB-first, one bit per clock, on a single-bit serial line, with idle fill between repetitions.
- Drives the x input of a downstream detector in the same clock domain, both as a bench stimulus source and as an on-chip test-pattern source.

Parameters:
- WIDTH, 8, pattern length in bits (2..32).
- CNT_W, 4, width of the repeat and gap fields.
- IDLE_BIT, 1'b0, level driven on x when not transmitting pattern bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- pattern  input  WIDTH  pattern word; bit WIDTH-1 is transmitted first.
- repeat  input  CNT_W  number of pattern repetitions (0 = none).
- gap  input  CNT_W  idle bits inserted between repetitions.
- abort  input  1  synchronous cancel of the current transfer.
- x  output  1  serial data out (registered).
- x_valid  output  1  high while x carries a pattern or parity bit (registered).
- busy  output  1  high in any state other than IDLE (registered).
- done  output  1  one-cycle pulse on normal completion (registered).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, x=IDLE_BIT, x_valid=0, busy=0, done=0, all counters 0. Reset overrides start and abort and applies mid-transfer with no done pulse.
- States: IDLE, SEND, GAP, FIN.
- IDLE, start=1:
  - Latch pattern, repeat and gap into shadow registers; later input changes have no effect.
  - If repeat!=0: go to SEND. At the same edge x=pattern[WIDTH-1], x_valid=1, busy=1. The first bit is therefore visible the cycle after start is sampled.
  - If repeat==0: go to FIN. x_valid stays 0.
- SEND:
  - Shift the shadow pattern left, one bit per cycle. WIDTH cycles per repetition, x_valid=1 throughout.
  - Bit counter runs 0..WIDTH-1. The repetition counter decrements after the last bit.
- End of a repetition:
  - Repetitions remaining and gap!=0: go to GAP (x=IDLE_BIT, x_valid=0) for exactly gap cycles, then SEND with the shadow pattern reloaded.
  - Repetitions remaining and gap==0: the next repetition's MSB follows the previous LSB with no idle cycle.
  - None remaining: go to FIN.
- FIN: exactly one cycle. done=1, busy=1, x=IDLE_BIT, x_valid=0. Next state is IDLE with done=0 and busy=0.
- start while busy: ignored, no queuing. The earliest accepted restart is the IDLE cycle after FIN.
- abort=1 in SEND, GAP or FIN: next state IDLE, x=IDLE_BIT, x_valid=0, busy=0, no done pulse. abort in IDLE has no effect. Same-edge start and abort in IDLE: start wins.
- Total busy cycles for a transfer = repeat*WIDTH + (repeat-1)*gap + 1 (FIN), for repeat>=1.
- Counter widths: repetition counter is CNT_W bits; bit counter is ceil(log2(WIDTH+1)) bits. No wrap occurs because the maximum repeat is 2^CNT_W-1.

Optional Feature:
- Macro SEQGEN_TX_PARITY_EN.
- Defined:
  - After each repetition's LSB, one extra cycle in SEND emits the even-parity bit of the latched pattern (XOR of all bits), with x_valid=1.
  - A repetition is then WIDTH+1 cycles, and the busy-cycle formula uses WIDTH+1.
  - Gap, FIN and abort rules are unchanged; abort during the parity cycle behaves as abort in SEND.
- Undefined: no parity logic or cycle; a repetition is exactly WIDTH bits.

Test Plan:
- Reset, then pattern=8'hA5, repeat=1, gap=0, start pulse -> x = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with x_valid=1, starting the cycle after start; done high on the 9th cycle; busy high for 9 cycles.
- pattern=8'b10010000, repeat=3, gap=2 -> 8 bits, 2 cycles x=0/x_valid=0, 8 bits, 2 idle cycles, 8 bits, then done. Total busy = 29 cycles; a chained 10010 detector fires 3 times.
- repeat=0, start -> no x_valid cycles; done pulses on the cycle after start; busy high for exactly 1 cycle.
- Transfer of 8'hFF, repeat=2; start re-pulsed during SEND; abort raised on the 5th bit -> the restart is ignored; next cycle x=IDLE_BIT, x_valid=0, busy=0; done never asserts.
- rst asserted during GAP of a repeat=2 transfer -> all outputs return to reset values at the next edge; a new start then transmits normally.
- With SEQGEN_TX_PARITY_EN defined, pattern=8'hA5 (four ones) -> 9 valid bits, the 9th being 0. With 8'hA4 the 9th bit is 1 and done arrives on the 10th cycle.

Source files
------------

// File: rtl/seqgen_tx.sv
// seqgen_tx: serial MSB-first pattern generator with repeat/gap control; SEQGEN_TX_PARITY_EN appends an even-parity bit per repetition
module seqgen_tx #(
  parameter int   WIDTH    = 8,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeats,
  input  logic [CNT_W-1:0] gap,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH + 1);
`ifdef SEQGEN_TX_PARITY_EN
  localparam logic [BW-1:0] LAST = BW'(WIDTH);
`else
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
`endif
  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
  state_t           state;
  logic [WIDTH-1:0] pat, sh;
  logic [CNT_W-1:0] rep_left, gap_r, gap_cnt;
  logic [BW-1:0]    bit_cnt;
`ifdef SEQGEN_TX_PARITY_EN
  logic             par;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pat      <= '0;
      sh       <= '0;
      rep_left <= '0;
      gap_r    <= '0;
      gap_cnt  <= '0;
      bit_cnt  <= '0;
`ifdef SEQGEN_TX_PARITY_EN
      par      <= 1'b0;
`endif
      x        <= IDLE_BIT;
      x_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort && state != IDLE) begin
      state   <= IDLE;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pat      <= pattern;
          sh       <= pattern << 1;
          rep_left <= repeats;
          gap_r    <= gap;
          bit_cnt  <= '0;
`ifdef SEQGEN_TX_PARITY_EN
          par      <= ^pattern;
`endif
          busy     <= 1'b1;
          x_valid  <= repeats != '0;
          x        <= repeats != '0 ? pattern[WIDTH-1] : IDLE_BIT;
          done     <= repeats == '0;
          state    <= repeats != '0 ? SEND : FIN;
        end
        SEND: if (bit_cnt != LAST) begin
          bit_cnt <= bit_cnt + 1'b1;
          sh      <= sh << 1;
`ifdef SEQGEN_TX_PARITY_EN
          x       <= bit_cnt == BW'(WIDTH - 1) ? par : sh[WIDTH-1];
`else
          x       <= sh[WIDTH-1];
`endif
        end else begin
          rep_left <= rep_left - 1'b1;
          bit_cnt  <= '0;
          if (rep_left == CNT_W'(1)) begin
            state   <= FIN;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            done    <= 1'b1;
          end else if (gap_r != '0) begin
            state   <= GAP;
            gap_cnt <= gap_r - 1'b1;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
          end else begin
            x  <= pat[WIDTH-1];
            sh <= pat << 1;
          end
        end
        GAP: if (gap_cnt == '0) begin
          state   <= SEND;
          x       <= pat[WIDTH-1];
          x_valid <= 1'b1;
          sh      <= pat << 1;
        end else begin
          gap_cnt <= gap_cnt - 1'b1;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seqgen_tx.sv
// tb_seqgen_tx: directed self-checking bench for seqgen_tx
module tb_seqgen_tx;
`ifdef SEQGEN_TX_PARITY_EN
  localparam int LEN = 9;
`else
  localparam int LEN = 8;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] repeats = '0;
  logic [3:0] gap = '0;
  logic       x, x_valid, busy, done;
  int         n_vec = 0;
  int         n_err = 0;
  int         nb;
  logic [8:0] xs;
  seqgen_tx #(.WIDTH(8), .CNT_W(4), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeats(repeats),
    .gap(gap), .abort(abort), .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [7:0] p, input logic [3:0] r,
                     input logic [3:0] g, input logic ab, output int busy_n, output logic [8:0] bits);
    logic [3:0] exp_q[$];
    int rr = int'(r);
    for (int k = 0; k < rr; k++) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back({p[i], 3'b110});
`ifdef SEQGEN_TX_PARITY_EN
      exp_q.push_back({^p, 3'b110});
`endif
      if (k < rr - 1) for (int j = 0; j < int'(g); j++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
    busy_n = 0;
    bits = '0;
    pattern = p; repeats = r; gap = g; start = 1'b1; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; pattern = ~p; repeats = 4'd0; gap = 4'd7;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), {x, x_valid, busy, done}, exp_q[i]);
      busy_n += int'(busy);
      if (x_valid) bits = {bits[7:0], x};
      if (i < exp_q.size() - 1) @(negedge clk);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_x", x, 1'b0);
    check("rst_xv", x_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    run("a5", 8'hA5, 4'd1, 4'd0, 1'b0, nb, xs);
    check("a5_busy", nb, LEN + 1);
`ifdef SEQGEN_TX_PARITY_EN
    check("a5_bits", xs, 9'h14A);
`else
    check("a5_bits", xs, 9'h0A5);
`endif
    run("a4", 8'hA4, 4'd1, 4'd0, 1'b0, nb, xs);
`ifdef SEQGEN_TX_PARITY_EN
    check("a4_bits", xs, 9'h149);
    check("a4_busy", nb, 10);
`else
    check("a4_bits", xs, 9'h0A4);
    check("a4_busy", nb, 9);
`endif
    run("r3g2", 8'b10010000, 4'd3, 4'd2, 1'b0, nb, xs);
    check("r3g2_busy", nb, LEN == 9 ? 32 : 29);
    run("r0", 8'h33, 4'd0, 4'd0, 1'b0, nb, xs);
    check("r0_busy", nb, 1);
    run("r2g0_ab", 8'h81, 4'd2, 4'd0, 1'b1, nb, xs);
    check("r2g0_busy", nb, 2 * LEN + 1);
    pattern = 8'hFF; repeats = 4'd2; gap = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("ff_bit%0d", i), {x, x_valid, busy, done}, 4'b1110);
      if (i == 2) begin start = 1'b1; pattern = 8'h00; end
      if (i == 3) start = 1'b0;
      if (i == 5) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ff_abort%0d", i), {x, x_valid, busy, done}, 4'b0000);
      @(negedge clk);
    end
    pattern = 8'hC3; repeats = 4'd2; gap = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LEN) @(negedge clk);
    check("c3_gap", {x, x_valid, busy, done}, 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    check("c3_rst", {x, x_valid, busy, done}, 4'b0000);
    rst = 1'b0;
    run("5a", 8'h5A, 4'd1, 4'd0, 1'b0, nb, xs);
`ifdef SEQGEN_TX_PARITY_EN
    check("5a_bits", xs, 9'h0B4);
`else
    check("5a_bits", xs, 9'h05A);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
